alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU in the RCPU datapath. It accepts operations from two independent requesters over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands and returns the registered F/ZF/OF result, tagged with the requester id, over a valid/ready response channel. Requester 0 is the instruction execute path; requester 1 is the address/branch-compare path.

## Interface
- WIDTH, 32, operand/result width; must match the ALU (32).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  ALU_OP code, passed through uninterpreted.
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: the same five signals for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the result (0/1).
- rsp_f  out  WIDTH  captured F.
- rsp_zf, rsp_of  out  1  captured ZF/OF.
- ALU_OP  out  3  to ALU.
- A, B  out  WIDTH  to ALU.
- F  in  WIDTH  from ALU.
- ZF, OF  in  1  from ALU.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: operands are applied to the ALU.
  - RESP: a result is held for the consumer.
- Arbitration:
  - Pointer `last` records the most recent grant. It resets to 1, so requester 0 wins the first contention.
  - Only one valid: that requester is selected.
  - Both valid: the requester other than `last` is selected.
- Accept condition:
  - reqN_ready is 1 only for the selected requester.
  - It is asserted only in IDLE, or in RESP when rsp_ready=1.
  - reqN_ready is combinational from the valids, state, `last` and rsp_ready.
  - Accept = reqN_valid & reqN_ready.
- On accept:
  - latch reqN_op/a/b into the ALU_OP/A/B registers and N into the id register;
  - set `last`=N;
  - go to EXEC.
- EXEC lasts exactly one cycle. At its closing edge, capture F/ZF/OF into rsp_f/rsp_zf/rsp_of, copy id to rsp_id, and go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_ready=0: stay in RESP; all rsp_* and ALU_OP/A/B hold stable.
  - rsp_ready=1 with an accept: go to EXEC (back-to-back).
  - rsp_ready=1 without an accept: go to IDLE.
- ALU_OP/A/B change only on accept. They hold the last operation otherwise, so the ALU inputs never glitch from requester activity.
- The arbiter never decodes op. Flags come from the ALU unmodified.
- Requester contract: once valid is raised, it and the payload stay stable until ready. The arbiter samples the payload only at the accept edge.
- Reset: asynchronous, and it applies mid-operation too. Any in-flight or held result is discarded and the FSM returns to IDLE.

## Timing
- Reset values:
  - state=IDLE, `last`=1;
  - rsp_valid=0, rsp_id=0, rsp_f=0, rsp_zf=0, rsp_of=0;
  - ALU_OP=3'b000, A=0, B=0;
  - req0_ready=0 and req1_ready=0 while rst_n=0.
- Latency: accept in cycle T → EXEC in T+1 → rsp_valid=1 in T+2.
- Throughput:
  - With rsp_ready held high and a requester always valid: one operation accepted every 2 cycles (accept in T, T+2, T+4, ...).
  - Otherwise: one operation per 3 cycles via IDLE.
- A result occupies the response slot until taken; no result is dropped or overwritten.
- Back-to-back: the new operation's operands reach the ALU at the same edge the old result leaves RESP.
- Contention fairness: with both requesters continuously valid, grants alternate 0,1,0,1,... starting with 0 after reset.

## Test plan
- Single ADD: reset, then req0 op=3'b100, A=32'hFFFF_FFFF, B=32'hFFFF_FFFF.
  - req0_ready in cycle 0.
  - rsp_valid in cycle 2 with rsp_id=0, rsp_f=32'hFFFF_FFFE, rsp_zf=0, rsp_of=0.
- Single SUB on requester 1: op=3'b101, A=32'h0FFF_FFFF, B=32'hFFFF_FFFF.
  - rsp_id=1, rsp_f=32'h1000_0000, rsp_zf=0, rsp_of=0.
- Contention: both valid continuously, rsp_ready=1, four operations each with distinct operands.
  - Grant order 0,1,0,1.
  - Accepts every 2 cycles.
  - Each rsp_id/rsp_f pairs correctly with its own operands.
- Backpressure: hold rsp_ready=0 for 5 cycles with a result pending and req0 valid.
  - rsp_* stable, rsp_valid=1, and req0_ready=0 throughout.
  - When rsp_ready=1, req0 is accepted in that same cycle.
- Zero flag: SUB with A=B=32'h1234_5678 gives rsp_f=0, rsp_zf=1.
- Reset mid-operation: assert rst_n=0 during EXEC and again during RESP.
  - rsp_valid=0 immediately and all outputs at their reset values.
  - After release, the first contended grant goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared 32-bit ALU.
// Operands are registered before they reach the ALU. The ALU result is
// captured one cycle later. That result is held on a valid/ready response
// channel, tagged with the id of the requester that issued it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_zf,
  output logic             rsp_of,
  output logic [2:0]       ALU_OP,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] F,
  input  logic             ZF,
  input  logic             OF
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last;       // most recent grant; requester 0 wins first contention
  logic       id;         // requester of the operation currently in the ALU
  logic       sel;
  logic       can_accept;
  logic       accept;

  // Round-robin select and handshake. Ready is gated by rst_n so neither
  // requester sees ready while reset is held.
  always_comb begin
    sel        = (req0_valid & req1_valid) ? ~last : req1_valid;
    can_accept = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
    req0_ready = can_accept & req0_valid & ~sel;
    req1_ready = can_accept & req1_valid & sel;
    accept     = req0_ready | req1_ready;
    rsp_valid  = (state == RESP);
  end

  // Sequencer FSM plus grant pointer and in-flight id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      id    <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (accept) state <= EXEC;
        EXEC:    state <= RESP;
        RESP:    if (rsp_ready) state <= accept ? EXEC : IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        last <= sel;
        id   <= sel;
      end
    end
  end

  // ALU operand registers change only on accept. The ALU inputs therefore
  // stay quiet while requesters toggle valid or payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_OP <= 3'b000;
      A      <= '0;
      B      <= '0;
    end else if (accept) begin
      ALU_OP <= sel ? req1_op : req0_op;
      A      <= sel ? req1_a  : req0_a;
      B      <= sel ? req1_b  : req0_b;
    end
  end

  // Capture the ALU result at the closing edge of EXEC and hold it in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id <= 1'b0;
      rsp_f  <= '0;
      rsp_zf <= 1'b0;
      rsp_of <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id <= id;
      rsp_f  <= F;
      rsp_zf <= ZF;
      rsp_of <= OF;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. It contains a behavioural ALU model
// and a response scoreboard.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op, ALU_OP;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, A, B, F, rsp_f;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zf, rsp_of, ZF, OF;

  typedef struct packed {
    logic         id;
    logic [W-1:0] f;
    logic         zf;
    logic         ovf;
  } rsp_t;

  rsp_t sb[$];
  rsp_t alu_out;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_f(rsp_f), .rsp_zf(rsp_zf), .rsp_of(rsp_of),
    .ALU_OP(ALU_OP), .A(A), .B(B), .F(F), .ZF(ZF), .OF(OF)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour: 100 ADD, 101 SUB, plus a few logic ops.
  function automatic rsp_t ref_rsp(input logic rid, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] f;
    logic o;
    o = 1'b0;
    case (op)
      3'b100: begin f = a + b; o = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]); end
      3'b101: begin f = a - b; o = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]); end
      3'b000: f = a & b;
      3'b001: f = a | b;
      3'b010: f = a ^ b;
      default: f = ~a;
    endcase
    return '{id: rid, f: f, zf: (f == '0), ovf: o};
  endfunction

  assign alu_out = ref_rsp(1'b0, ALU_OP, A, B);
  assign F  = alu_out.f;
  assign ZF = alu_out.zf;
  assign OF = alu_out.ovf;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'h1; req0_b = 32'h2;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'h3; req1_b = 32'h4;
    #12;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if ({rsp_id, rsp_f, rsp_zf, rsp_of} !== 35'h0) $display("FAIL reset_rsp: got %h want 0", {rsp_id, rsp_f, rsp_zf, rsp_of}); else n_pass++;
    n_checks++; if ({ALU_OP, A, B} !== 67'h0) $display("FAIL reset_alu_in: got %h want 0", {ALU_OP, A, B}); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // One isolated operation from requester rid: ready in cycle 0, response in cycle 2.
  task automatic test_single(input logic rid, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] ef,
                             input logic ezf, input logic eof);
    rsp_t e;
    tick();
    rsp_ready = 1'b1;
    if (rid) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else     begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    sb.push_back('{id: rid, f: ef, zf: ezf, ovf: eof});
    @(negedge clk);
    n_checks++; if ((rid ? req1_ready : req0_ready) !== 1'b1) $display("FAIL single_ready id%0d: got 0 want 1", rid); else n_pass++;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_exec_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if ({ALU_OP, A, B} !== {op, a, b}) $display("FAIL single_alu_in: got %h want %h", {ALU_OP, A, B}, {op, a, b}); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    e = sb.pop_front();
    n_checks++; if ({rsp_id, rsp_f, rsp_zf, rsp_of} !== e) $display("FAIL single_rsp: got %h want %h", {rsp_id, rsp_f, rsp_zf, rsp_of}, e); else n_pass++;
    tick();
  endtask

  task automatic test_contention();
    logic [W-1:0] a0[2], b0[2], a1[2], b1[2];
    rsp_t e;
    int i0 = 0, i1 = 0, cyc = 0, last_acc = 0, nacc = 0, nrsp = 0;
    logic acc0, acc1;
    a0 = '{32'h0000_0011, 32'h7FFF_FFFF}; b0 = '{32'h0000_0022, 32'h0000_0001};
    a1 = '{32'h0000_0100, 32'h8000_0000}; b1 = '{32'h0000_0001, 32'h0000_0001};
    @(negedge clk); rst_n = 1'b0; #2; rst_n = 1'b1;
    sb.delete();
    sb.push_back(ref_rsp(1'b0, 3'b100, a0[0], b0[0]));
    sb.push_back(ref_rsp(1'b1, 3'b101, a1[0], b1[0]));
    sb.push_back(ref_rsp(1'b0, 3'b100, a0[1], b0[1]));
    sb.push_back(ref_rsp(1'b1, 3'b101, a1[1], b1[1]));
    tick();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = a0[0]; req0_b = b0[0];
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = a1[0]; req1_b = b1[0];
    while (nrsp < 4 && cyc < 40) begin
      @(negedge clk);
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (rsp_valid && rsp_ready) begin
        e = sb.pop_front();
        n_checks++; if ({rsp_id, rsp_f, rsp_zf, rsp_of} !== e) $display("FAIL cont_rsp%0d: got %h want %h", nrsp, {rsp_id, rsp_f, rsp_zf, rsp_of}, e); else n_pass++;
        nrsp++;
      end
      if (acc0 || acc1) begin
        n_checks++; if ({acc1, acc0} !== ((nacc % 2) ? 2'b10 : 2'b01)) $display("FAIL cont_grant%0d: got %b want %b", nacc, {acc1, acc0}, (nacc % 2) ? 2'b10 : 2'b01); else n_pass++;
        if (nacc > 0) begin
          n_checks++; if (cyc - last_acc !== 2) $display("FAIL cont_spacing%0d: got %0d want 2", nacc, cyc - last_acc); else n_pass++;
        end
        last_acc = cyc;
        nacc++;
      end
      tick();
      if (acc0) begin i0++; if (i0 < 2) begin req0_a = a0[i0]; req0_b = b0[i0]; end else req0_valid = 1'b0; end
      if (acc1) begin i1++; if (i1 < 2) begin req1_a = a1[i1]; req1_b = b1[i1]; end else req1_valid = 1'b0; end
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (nrsp !== 4) $display("FAIL cont_timeout: got %0d responses want 4", nrsp); else n_pass++;
    n_checks++; if (nacc !== 4) $display("FAIL cont_accepts: got %0d want 4", nacc); else n_pass++;
  endtask

  task automatic test_backpressure();
    rsp_t e;
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'h5; req0_b = 32'h7;
    sb.push_back('{id: 1'b0, f: 32'h0000_000C, zf: 1'b0, ovf: 1'b0});
    @(negedge clk);
    tick();
    req0_op = 3'b101; req0_a = 32'h3; req0_b = 32'h9;
    sb.push_back('{id: 1'b0, f: 32'hFFFF_FFFA, zf: 1'b0, ovf: 1'b0});
    @(negedge clk);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if ({rsp_valid, req0_ready} !== 2'b10) $display("FAIL bp_hs%0d: got %b want 10", k, {rsp_valid, req0_ready}); else n_pass++;
      n_checks++; if ({rsp_id, rsp_f, rsp_zf, rsp_of} !== sb[0]) $display("FAIL bp_hold%0d: got %h want %h", k, {rsp_id, rsp_f, rsp_zf, rsp_of}, sb[0]); else n_pass++;
      n_checks++; if (A !== 32'h5) $display("FAIL bp_alu_a%0d: got %h want 5", k, A); else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req0_ready); else n_pass++;
    e = sb.pop_front();
    n_checks++; if ({rsp_id, rsp_f, rsp_zf, rsp_of} !== e) $display("FAIL bp_rsp1: got %h want %h", {rsp_id, rsp_f, rsp_zf, rsp_of}, e); else n_pass++;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({ALU_OP, A} !== {3'b101, 32'h3}) $display("FAIL bp_b2b_alu: got %h want %h", {ALU_OP, A}, {3'b101, 32'h3}); else n_pass++;
    tick();
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if ({rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of} !== {1'b1, e}) $display("FAIL bp_rsp2: got %h want %h", {rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of}, {1'b1, e}); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_t e;
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'h1; req0_b = 32'h2;
    tick();
    req0_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of} !== 36'h0) $display("FAIL rmid_exec_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of}); else n_pass++;
    n_checks++; if ({ALU_OP, A, B} !== 67'h0) $display("FAIL rmid_exec_alu: got %h want 0", {ALU_OP, A, B}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    tick();
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'h3; req1_b = 32'h4;
    tick();
    req1_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_f} !== {1'b1, 1'b1, 32'h7}) $display("FAIL rmid_pre_resp: got %h want %h", {rsp_valid, rsp_id, rsp_f}, {1'b1, 1'b1, 32'h7}); else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of} !== 36'h0) $display("FAIL rmid_resp_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of}); else n_pass++;
    n_checks++; if ({ALU_OP, A, B} !== 67'h0) $display("FAIL rmid_resp_alu: got %h want 0", {ALU_OP, A, B}); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    sb.delete();
    tick();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'b100; req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'd50; req1_b = 32'd8;
    sb.push_back('{id: 1'b0, f: 32'd30, zf: 1'b0, ovf: 1'b0});
    sb.push_back('{id: 1'b1, f: 32'd42, zf: 1'b0, ovf: 1'b0});
    @(negedge clk);
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rmid_first_grant: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if ({rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of} !== {1'b1, e}) $display("FAIL rmid_rsp0: got %h want %h", {rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of}, {1'b1, e}); else n_pass++;
    n_checks++; if (req1_ready !== 1'b1) $display("FAIL rmid_req1_b2b: got %b want 1", req1_ready); else n_pass++;
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    e = sb.pop_front();
    n_checks++; if ({rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of} !== {1'b1, e}) $display("FAIL rmid_rsp1: got %h want %h", {rsp_valid, rsp_id, rsp_f, rsp_zf, rsp_of}, {1'b1, e}); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    test_single(1'b1, 3'b101, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'h1000_0000, 1'b0, 1'b0);
    test_single(1'b0, 3'b101, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0);
    test_contention();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
